// File: rtl/riscv32_fetch_stage.sv
// riscv32_fetch_stage: RV32 instruction fetch with at most one outstanding
// instruction-memory request and a registered IF/ID presentation register.
// Build option: define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect
// targets (adds the if_misaligned port); otherwise targets are word-aligned.
module riscv32_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        async_rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_inst
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        if_misaligned
`endif
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] INST_BYTES = XLEN'(4);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic            r_if_valid, w_if_valid_nxt;
  logic [XLEN-1:0] r_if_pc, w_if_pc_nxt;
  logic [XLEN-1:0] r_if_pc4, w_if_pc4_nxt;
  logic [XLEN-1:0] r_if_inst, w_if_inst_nxt;
  // A trap taken while a response is still owed must swallow that response.
  logic            r_rsp_owed, w_rsp_owed_nxt;
  logic            w_req_valid;
  logic [XLEN-1:0] w_redir_pc;
  logic            w_trap;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_misaligned;

  assign w_redir_pc = redirect_pc;
  assign w_trap     = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign w_redir_pc = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_trap     = 1'b0;
`endif

  // Next-state and next-register logic for the fetch FSM.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_if_valid_nxt = r_if_valid;
    w_if_pc_nxt    = r_if_pc;
    w_if_pc4_nxt   = r_if_pc4;
    w_if_inst_nxt  = r_if_inst;
    w_rsp_owed_nxt = r_rsp_owed && !imem_rsp_valid;
    w_req_valid    = 1'b0;

    unique case (r_state)
      S_REQ: begin
        w_req_valid = !redirect_valid;
        if (redirect_valid) begin
          w_pc_nxt = w_redir_pc;
        end else if (imem_req_ready) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = imem_rsp_valid ? S_REQ : S_DROP;
        end else if (imem_rsp_valid) begin
          w_if_valid_nxt = 1'b1;
          w_if_pc_nxt    = r_pc;
          w_if_pc4_nxt   = r_pc + INST_BYTES;
          w_if_inst_nxt  = imem_rsp_data;
          w_pc_nxt       = r_pc + INST_BYTES;
          w_state_nxt    = S_HOLD;
        end
      end
      S_DROP: begin
        if (redirect_valid) begin
          w_pc_nxt = w_redir_pc;
        end
        if (imem_rsp_valid) begin
          w_state_nxt = S_REQ;
        end
      end
      S_HOLD: begin
        if (redirect_valid || id_ready) begin
          w_if_valid_nxt = 1'b0;
          w_state_nxt    = (r_rsp_owed && !imem_rsp_valid) ? S_DROP : S_REQ;
          if (redirect_valid) begin
            w_pc_nxt = w_redir_pc;
          end
        end
      end
      default: begin
        w_state_nxt = S_REQ;
      end
    endcase

    // Misaligned target: present a NOP at the target instead of fetching.
    if (w_trap) begin
      w_state_nxt    = S_HOLD;
      w_if_valid_nxt = 1'b1;
      w_if_pc_nxt    = redirect_pc;
      w_if_pc4_nxt   = redirect_pc + INST_BYTES;
      w_if_inst_nxt  = NOP_INST;
      w_pc_nxt       = redirect_pc;
      w_rsp_owed_nxt = (r_rsp_owed || (r_state == S_WAIT) || (r_state == S_DROP))
                       && !imem_rsp_valid;
    end
  end

  // FSM state, pc and IF/ID presentation registers.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC;
      r_if_valid <= 1'b0;
      r_if_pc    <= '0;
      r_if_pc4   <= '0;
      r_if_inst  <= '0;
      r_rsp_owed <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_if_valid <= w_if_valid_nxt;
      r_if_pc    <= w_if_pc_nxt;
      r_if_pc4   <= w_if_pc4_nxt;
      r_if_inst  <= w_if_inst_nxt;
      r_rsp_owed <= w_rsp_owed_nxt;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Misaligned flag: set by a trap, cleared when the trapped NOP leaves HOLD.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_misaligned <= 1'b0;
    end else if (w_trap) begin
      r_misaligned <= 1'b1;
    end else if ((r_state == S_HOLD) && (redirect_valid || id_ready)) begin
      r_misaligned <= 1'b0;
    end
  end

  assign if_misaligned = r_misaligned;
`endif

  // The request strobe is suppressed during reset so memory never sees a stray request.
  assign imem_req_valid = w_req_valid && !async_rst;
  assign imem_req_addr  = r_pc;
  assign if_valid       = r_if_valid;
  assign if_pc          = r_if_pc;
  assign if_pc_plus4    = r_if_pc4;
  assign if_inst        = r_if_inst;

endmodule

// File: tb/tb_riscv32_fetch_stage.sv
// tb_riscv32_fetch_stage: scenario tasks plus a randomized run against an
// instruction-stream reference model and a single-outstanding memory model.
module tb_riscv32_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        async_rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_ready = 1'b0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_inst;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        if_misaligned;
`endif

  riscv32_fetch_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk(clk), .async_rst(async_rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .id_ready(id_ready),
    .if_valid(if_valid), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .if_inst(if_inst)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .if_misaligned(if_misaligned)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Drive intent for the next cycle.
  bit          drv_rst = 1'b1;
  bit          drv_ready = 1'b0;
  bit          drv_id_ready = 1'b0;
  bit          drv_redir = 1'b0;
  logic [31:0] drv_redir_pc = '0;
  int          lat = 1;

  // Memory model state.
  bit          m_pend = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_addr = '0;
  bit          mem_err = 1'b0;

  // Per-cycle observations.
  bit          pre_req_valid, pre_if_valid, last_acc, last_rsp;
  logic [31:0] last_acc_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'hC0DE_0000) + 32'h0000_0013;
  endfunction

  // One clock: drive at negedge, sample handshakes just after, update memory at posedge.
  task automatic cycle();
    @(negedge clk);
    async_rst      = drv_rst;
    imem_rsp_valid = m_pend && (m_cnt == 0) && !drv_rst;
    imem_rsp_data  = imem_rsp_valid ? mem_word(m_addr) : 32'($urandom());
    imem_req_ready = drv_ready;
    redirect_valid = drv_redir;
    redirect_pc    = drv_redir_pc;
    id_ready       = drv_id_ready;
    #1;
    pre_req_valid = imem_req_valid;
    pre_if_valid  = if_valid;
    last_acc      = imem_req_valid && imem_req_ready;
    last_acc_addr = imem_req_addr;
    last_rsp      = imem_rsp_valid;
    @(posedge clk);
    if (async_rst) begin
      m_pend = 1'b0;
    end else begin
      if (last_rsp) m_pend = 1'b0;
      else if (m_pend && m_cnt != 0) m_cnt--;
      if (last_acc) begin
        if (m_pend) mem_err = 1'b1;
        m_pend = 1'b1;
        m_cnt  = lat - 1;
        m_addr = last_acc_addr;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    drv_rst = 1'b1; drv_redir = 1'b0;
    cycle(); cycle();
    drv_rst = 1'b0;
  endtask

  task automatic run_until_acc(output bit got);
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (last_acc) begin got = 1'b1; break; end
    end
  endtask

  task automatic run_until_valid(output bit got);
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (if_valid) begin got = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    drv_ready = 1'b1; drv_id_ready = 1'b1;
    do_reset();
    n_cmp++; if (pre_req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_req_valid: got %b want 0", pre_req_valid); end
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rst_if_valid: got %b want 0", if_valid); end
    n_cmp++; if ({if_pc, if_pc_plus4, if_inst} !== 96'h0) begin n_bad++; $display("FAIL rst_if_regs: got %h want 0", {if_pc, if_pc_plus4, if_inst}); end
    n_cmp++; if (imem_req_addr !== RESET_PC) begin n_bad++; $display("FAIL rst_pc: got %h want %h", imem_req_addr, RESET_PC); end
  endtask

  task automatic test_sequential();
    bit exp_acc, exp_v;
    drv_ready = 1'b1; drv_id_ready = 1'b1; lat = 1;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cycle();
      exp_acc = (i % 3 == 0);
      exp_v   = (i % 3 == 1);
      n_cmp++; if (last_acc !== exp_acc) begin n_bad++; $display("FAIL seq_acc[%0d]: got %b want %b", i, last_acc, exp_acc); end
      if (exp_acc) begin
        n_cmp++; if (last_acc_addr !== 32'(i / 3 * 4)) begin n_bad++; $display("FAIL seq_addr[%0d]: got %h want %h", i, last_acc_addr, 32'(i / 3 * 4)); end
      end
      n_cmp++; if (if_valid !== exp_v) begin n_bad++; $display("FAIL seq_valid[%0d]: got %b want %b", i, if_valid, exp_v); end
      if (exp_v) begin
        n_cmp++; if (if_pc !== 32'(i / 3 * 4)) begin n_bad++; $display("FAIL seq_pc[%0d]: got %h want %h", i, if_pc, 32'(i / 3 * 4)); end
        n_cmp++; if (if_inst !== mem_word(32'(i / 3 * 4))) begin n_bad++; $display("FAIL seq_inst[%0d]: got %h want %h", i, if_inst, mem_word(32'(i / 3 * 4))); end
      end
    end
  endtask

  task automatic test_latency();
    bit got;
    int n;
    int lats[3] = '{1, 2, 4};
    foreach (lats[j]) begin
      drv_ready = 1'b1; drv_id_ready = 1'b1; lat = lats[j];
      do_reset();
      run_until_acc(got);
      n = 0;
      for (int k = 0; k < 20; k++) begin
        cycle(); n++;
        if (if_valid) break;
      end
      n_cmp++; if (n !== lats[j]) begin n_bad++; $display("FAIL latency_%0d: got %0d edges want %0d", lats[j], n, lats[j]); end
    end
  endtask

  task automatic test_stall();
    bit got;
    drv_ready = 1'b1; drv_id_ready = 1'b0; lat = 1;
    do_reset();
    run_until_valid(got);
    n_cmp++; if (!got) begin n_bad++; $display("FAIL stall_timeout: got no if_valid want if_valid"); end
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_cmp++; if (pre_req_valid !== 1'b0) begin n_bad++; $display("FAIL stall_req[%0d]: got %b want 0", i, pre_req_valid); end
      n_cmp++; if ({if_valid, if_pc, if_inst} !== {1'b1, 32'h0, mem_word(32'h0)}) begin n_bad++; $display("FAIL stall_hold[%0d]: got %b/%h/%h want 1/0/%h", i, if_valid, if_pc, if_inst, mem_word(32'h0)); end
    end
    drv_id_ready = 1'b1;
    cycle();
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL stall_release: got %b want 0", if_valid); end
    cycle();
    n_cmp++; if (!last_acc || last_acc_addr !== 32'h4) begin n_bad++; $display("FAIL stall_next: got %b/%h want 1/00000004", last_acc, last_acc_addr); end
  endtask

  task automatic test_redirect_wait();
    bit got, seen_v;
    drv_ready = 1'b1; drv_id_ready = 1'b1; lat = 3;
    do_reset();
    run_until_acc(got);
    drv_redir = 1'b1; drv_redir_pc = 32'h100;
    cycle();
    drv_redir = 1'b0;
    seen_v = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (if_valid) seen_v = 1'b1;
      if (last_acc) begin got = 1'b1; break; end
    end
    n_cmp++; if (seen_v !== 1'b0) begin n_bad++; $display("FAIL rdw_stale: got if_valid want none"); end
    n_cmp++; if (!got || last_acc_addr !== 32'h100) begin n_bad++; $display("FAIL rdw_addr: got %b/%h want 1/00000100", got, last_acc_addr); end
    n_cmp++; if (mem_err !== 1'b0) begin n_bad++; $display("FAIL rdw_outstanding: got %b want 0", mem_err); end
    run_until_valid(got);
    n_cmp++; if (!got || if_pc !== 32'h100 || if_inst !== mem_word(32'h100)) begin n_bad++; $display("FAIL rdw_pc: got %h/%h want 00000100/%h", if_pc, if_inst, mem_word(32'h100)); end
    n_cmp++; if (if_pc_plus4 !== 32'h104) begin n_bad++; $display("FAIL rdw_pc4: got %h want 00000104", if_pc_plus4); end
  endtask

  task automatic test_drop_redirect();
    bit got;
    drv_ready = 1'b1; drv_id_ready = 1'b1; lat = 4;
    do_reset();
    run_until_acc(got);
    drv_redir = 1'b1; drv_redir_pc = 32'h300;
    cycle();
    drv_redir_pc = 32'h340;
    cycle();
    drv_redir = 1'b0;
    run_until_acc(got);
    n_cmp++; if (!got || last_acc_addr !== 32'h340) begin n_bad++; $display("FAIL drop_redir_addr: got %b/%h want 1/00000340", got, last_acc_addr); end
  endtask

  task automatic test_redirect_rsp();
    bit got;
    drv_ready = 1'b1; drv_id_ready = 1'b1; lat = 2;
    do_reset();
    run_until_acc(got);
    for (int k = 0; k < 10 && !(m_pend && m_cnt == 0); k++) cycle();
    drv_redir = 1'b1; drv_redir_pc = 32'h200;
    cycle();
    drv_redir = 1'b0;
    n_cmp++; if (last_rsp !== 1'b1) begin n_bad++; $display("FAIL rdr_coincide: got rsp %b want 1", last_rsp); end
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rdr_valid: got %b want 0", if_valid); end
    cycle();
    n_cmp++; if (!last_acc || last_acc_addr !== 32'h200) begin n_bad++; $display("FAIL rdr_addr: got %b/%h want 1/00000200", last_acc, last_acc_addr); end
  endtask

  task automatic test_misalign();
    bit got;
    drv_ready = 1'b1; drv_id_ready = 1'b1; lat = 1;
    do_reset();
    drv_redir = 1'b1; drv_redir_pc = 32'h102;
    cycle();
    drv_redir = 1'b0;
    n_cmp++; if (last_acc !== 1'b0) begin n_bad++; $display("FAIL mis_noreq: got %b want 0", last_acc); end
`ifdef FETCH_MISALIGN_TRAP_EN
    n_cmp++; if ({if_valid, if_misaligned, if_pc, if_inst} !== {2'b11, 32'h102, NOP_INST}) begin n_bad++; $display("FAIL mis_trap: got %b%b/%h/%h want 11/00000102/%h", if_valid, if_misaligned, if_pc, if_inst, NOP_INST); end
    cycle();
    n_cmp++; if (last_acc !== 1'b0) begin n_bad++; $display("FAIL mis_hold_noreq: got %b want 0", last_acc); end
    n_cmp++; if ({if_valid, if_misaligned} !== 2'b00) begin n_bad++; $display("FAIL mis_clear: got %b%b want 00", if_valid, if_misaligned); end
`else
    run_until_acc(got);
    n_cmp++; if (!got || last_acc_addr !== 32'h100) begin n_bad++; $display("FAIL mis_align_addr: got %b/%h want 1/00000100", got, last_acc_addr); end
`endif
  endtask

  task automatic test_wrap();
    bit got;
    drv_ready = 1'b1; drv_id_ready = 1'b0; lat = 1;
    do_reset();
    drv_redir = 1'b1; drv_redir_pc = 32'hFFFF_FFFC;
    cycle();
    drv_redir = 1'b0;
    run_until_acc(got);
    n_cmp++; if (!got || last_acc_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_addr0: got %b/%h want 1/fffffffc", got, last_acc_addr); end
    run_until_valid(got);
    n_cmp++; if (if_pc !== 32'hFFFF_FFFC || if_pc_plus4 !== 32'h0) begin n_bad++; $display("FAIL wrap_pc4: got %h/%h want fffffffc/00000000", if_pc, if_pc_plus4); end
    drv_id_ready = 1'b1;
    run_until_acc(got);
    n_cmp++; if (!got || last_acc_addr !== 32'h0) begin n_bad++; $display("FAIL wrap_next: got %b/%h want 1/00000000", got, last_acc_addr); end
  endtask

  task automatic test_reset_mid();
    bit got;
    drv_ready = 1'b1; drv_id_ready = 1'b1; lat = 3;
    do_reset();
    drv_redir = 1'b1; drv_redir_pc = 32'h500;
    cycle();
    drv_redir = 1'b0;
    run_until_acc(got);
    #2;
    async_rst = 1'b1; drv_rst = 1'b1; m_pend = 1'b0;
    #1;
    n_cmp++; if ({imem_req_valid, if_valid} !== 2'b00) begin n_bad++; $display("FAIL rmid_strobes: got %b%b want 00", imem_req_valid, if_valid); end
    n_cmp++; if (imem_req_addr !== RESET_PC) begin n_bad++; $display("FAIL rmid_pc: got %h want %h", imem_req_addr, RESET_PC); end
    cycle(); cycle();
    drv_rst = 1'b0;
    cycle();
    n_cmp++; if (!last_acc || last_acc_addr !== RESET_PC) begin n_bad++; $display("FAIL rmid_first: got %b/%h want 1/%h", last_acc, last_acc_addr, RESET_PC); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    bit consumed;
    int n_consumed = 0;
    mem_err = 1'b0;
    drv_ready = 1'b1; drv_id_ready = 1'b1; lat = 1;
    do_reset();
    exp_pc = RESET_PC;
    for (int i = 0; i < 800; i++) begin
      drv_ready    = bit'($urandom_range(0, 1));
      drv_id_ready = ($urandom_range(0, 3) != 0);
      drv_redir    = ($urandom_range(0, 15) == 0);
      drv_redir_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : 32'($urandom());
`ifdef FETCH_MISALIGN_TRAP_EN
      drv_redir_pc = drv_redir_pc & 32'hFFFF_FFFC;
`endif
      lat = int'($urandom_range(1, 4));
      cycle();
      consumed = pre_if_valid && drv_id_ready && !drv_redir;
      if (drv_redir) begin
        n_cmp++; if (pre_req_valid !== 1'b0) begin n_bad++; $display("FAIL rnd_req_on_redir[%0d]: got %b want 0", i, pre_req_valid); end
      end
      if (last_acc) begin
        n_cmp++; if (last_acc_addr !== exp_pc) begin n_bad++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, last_acc_addr, exp_pc); end
      end
      if (consumed) begin exp_pc = exp_pc + 32'd4; n_consumed++; end
      if (drv_redir) exp_pc = drv_redir_pc & 32'hFFFF_FFFC;
      if (consumed || drv_redir) begin
        n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rnd_exit[%0d]: got %b want 0", i, if_valid); end
      end
      if (if_valid) begin
        n_cmp++; if ({if_pc, if_pc_plus4, if_inst} !== {exp_pc, exp_pc + 32'd4, mem_word(exp_pc)}) begin n_bad++; $display("FAIL rnd_present[%0d]: got %h/%h/%h want %h/%h/%h", i, if_pc, if_pc_plus4, if_inst, exp_pc, exp_pc + 32'd4, mem_word(exp_pc)); end
      end
    end
    drv_redir = 1'b0;
    n_cmp++; if (mem_err !== 1'b0) begin n_bad++; $display("FAIL rnd_outstanding: got %b want 0", mem_err); end
    n_cmp++; if (n_consumed < 20) begin n_bad++; $display("FAIL rnd_progress: got %0d consumed want >=20", n_consumed); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_latency();
    test_stall();
    test_redirect_wait();
    test_drop_redirect();
    test_redirect_rsp();
    test_misalign();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
